// File: rtl/pll_cfg_seq_if.sv
// Request handshake between the SPI register-map decode and the PLL configuration sequencer.
// The decoder is the master and drives the request; the sequencer is the slave and answers with ready.
interface pll_cfg_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_pllen;
   logic [9:0] req_ratio;

   modport master (output req_valid, output req_pllen, output req_ratio, input req_ready);
   modport slave  (input req_valid, input req_pllen, input req_ratio, output req_ready);
endinterface

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: bypasses the clock, powers the PLL down to settle, loads the new ratio,
// waits for a stable lock (or a timeout), then releases bypass. It also watches for lock loss while idle.
module pll_cfg_seq #(
   parameter int SETTLE_CYC   = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int LOCK_STABLE  = 8,
   parameter int RATIO_MIN    = 2,
   parameter int RESET_RATIO  = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   pll_cfg_seq_if.slave        req,
   input  logic                pll_lock,
   output logic                pll_en,
   output logic [9:0]          pll_ratio,
   output logic                pll_bypass,
   output logic                busy,
   output logic                done,
   output logic [1:0]          err,
   output logic                lock_lost
);

   localparam int SET_W = $clog2(SETTLE_CYC) + 1;
   localparam int STB_W = $clog2(LOCK_STABLE) + 1;
   localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);

   localparam logic [1:0] ERR_OK        = 2'd0;
   localparam logic [1:0] ERR_BAD_RATIO = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

   typedef enum logic [2:0] {IDLE, BYP, OFF, LOAD, WAIT_LOCK, RELEASE} state_t;

   state_t             state;
   logic [SET_W-1:0]   settle_cnt;
   logic [STB_W-1:0]   stable_cnt;
   logic [TO_W-1:0]    timeout_cnt;
   logic               cap_pllen;
   logic [9:0]         cap_ratio;

   logic               accept;
   logic [STB_W-1:0]   stable_inc;
   logic [TO_W-1:0]    timeout_inc;
   logic               lock_hit;
   logic               timeout_hit;

   assign req.req_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign accept        = req.req_valid && (state == IDLE);

   // Saturating next values; lock is checked first so a simultaneous timeout loses.
   always_comb begin
      stable_inc  = (stable_cnt == STB_MAX) ? STB_MAX : stable_cnt + 1'b1;
      timeout_inc = (timeout_cnt == TO_MAX) ? TO_MAX : timeout_cnt + 1'b1;
      lock_hit    = pll_lock && (stable_inc == STB_MAX);
      timeout_hit = (timeout_inc == TO_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pll_en      <= 1'b0;
         pll_ratio   <= 10'(RESET_RATIO);
         pll_bypass  <= 1'b1;
         done        <= 1'b0;
         err         <= ERR_OK;
         lock_lost   <= 1'b0;
         settle_cnt  <= '0;
         stable_cnt  <= '0;
         timeout_cnt <= '0;
         cap_pllen   <= 1'b0;
         cap_ratio   <= 10'(RESET_RATIO);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lock_lost <= 1'b0;
                  if (req.req_ratio < 10'(RATIO_MIN)) begin
                     done <= 1'b1;
                     err  <= ERR_BAD_RATIO;
                  end else begin
                     cap_pllen  <= req.req_pllen;
                     cap_ratio  <= req.req_ratio;
                     err        <= ERR_OK;
                     pll_bypass <= 1'b1;
                     state      <= BYP;
                  end
               end else if (pll_en && !pll_bypass && !pll_lock) begin
                  lock_lost  <= 1'b1;
                  pll_bypass <= 1'b1;
               end
            end
            BYP: begin
               pll_en     <= 1'b0;
               settle_cnt <= '0;
               state      <= OFF;
            end
            // The ratio only changes after the PLL has been held off for the full settle time.
            OFF: begin
               if (settle_cnt == SET_LAST) begin
                  settle_cnt <= '0;
                  if (cap_pllen) begin
                     pll_ratio <= cap_ratio;
                     state     <= LOAD;
                  end else begin
                     done  <= 1'b1;
                     err   <= ERR_OK;
                     state <= IDLE;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            LOAD: begin
               pll_en      <= 1'b1;
               stable_cnt  <= '0;
               timeout_cnt <= '0;
               state       <= WAIT_LOCK;
            end
            WAIT_LOCK: begin
               stable_cnt  <= pll_lock ? stable_inc : '0;
               timeout_cnt <= timeout_inc;
               if (lock_hit) begin
                  state <= RELEASE;
               end else if (timeout_hit) begin
                  pll_en <= 1'b0;
                  done   <= 1'b1;
                  err    <= ERR_TIMEOUT;
                  state  <= IDLE;
               end
            end
            RELEASE: begin
               pll_bypass <= 1'b0;
               done       <= 1'b1;
               err        <= ERR_OK;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pll_cfg_seq.md
PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 16, cycles pll_en held low before new ratio is loaded.
REQ-002 Parameter LOCK_TIMEOUT, default 4096, max cycles waited for lock after enable.
REQ-003 Parameter LOCK_STABLE, default 8, consecutive pll_lock-high cycles required to declare lock.
REQ-004 Parameter RATIO_MIN, default 2, smallest legal ratio; RESET_RATIO, default 6, ratio driven out of reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  configuration request present (from SPI register map decode).
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_pllen  input  1  requested PLL enable.
REQ-010 req_ratio  input  10  requested feedback ratio.
REQ-011 pll_lock  input  1  PLL lock indicator; treated as already synchronous to clk.
REQ-012 pll_en  output  1  PLL enable to analog macro.
REQ-013 pll_ratio  output  10  ratio to analog macro.
REQ-014 pll_bypass  output  1  1 = downstream clock mux selects reference clock.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  single-cycle pulse at end of every accepted request.
REQ-017 err  output  2  result code, valid with done and held until next accept: 0 OK, 1 BAD_RATIO, 2 TIMEOUT.
REQ-018 lock_lost  output  1  sticky flag: lock dropped while running.

Function
REQ-019 States SHALL be IDLE, BYP, OFF, LOAD, WAIT_LOCK, RELEASE; encoding is implementation choice.
REQ-020 req_ready SHALL equal (state==IDLE); request accepted on the cycle req_valid && req_ready; inputs sampled only then.
REQ-021 Accept with req_ratio < RATIO_MIN SHALL stay in IDLE, leave pll_en/pll_ratio/pll_bypass unchanged, pulse done next cycle with err=1.
REQ-022 Valid accept SHALL go to BYP; BYP drives pll_bypass=1 for exactly one cycle, then OFF.
REQ-023 OFF SHALL drive pll_en=0 and count SETTLE_CYC cycles; exit to LOAD if req_pllen=1, else to IDLE with done pulse, err=0, pll_bypass left 1.
REQ-024 LOAD SHALL register pll_ratio<=captured ratio for one cycle with pll_en=0, then WAIT_LOCK.
REQ-025 WAIT_LOCK SHALL drive pll_en=1; stable counter increments on pll_lock=1, clears to 0 on pll_lock=0.
REQ-026 Stable counter reaching LOCK_STABLE SHALL move to RELEASE; RELEASE drives pll_bypass<=0, pulses done with err=0, returns to IDLE (one cycle).
REQ-027 Timeout counter SHALL count cycles in WAIT_LOCK; at LOCK_TIMEOUT without lock: pll_en<=0, pll_bypass stays 1, done pulse, err=2, IDLE.
REQ-028 Lock and timeout reached on same cycle: lock wins (err=0).
REQ-029 In IDLE with pll_en=1 and pll_bypass=0, pll_lock=0 SHALL set lock_lost and force pll_bypass=1 the next cycle; pll_en unchanged.
REQ-030 lock_lost SHALL clear only on the next accepted request (any err outcome).
REQ-031 Counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter +1.
REQ-032 req_valid held high across done SHALL be re-accepted in the cycle after return to IDLE (no combinational ready->valid path).
REQ-033 Total latency pllen=1 with immediate stable lock: 1 (BYP) + SETTLE_CYC + 1 (LOAD) + LOCK_STABLE + 1 (RELEASE) cycles from accept to done.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, pll_en=0, pll_ratio=RESET_RATIO, pll_bypass=1, busy=0, done=0, err=0, lock_lost=0, counters 0.
REQ-035 Reset mid-sequence SHALL abort without done pulse; req_ready high on first clock after rst_n release.

Verification
REQ-036 Reset release, req pllen=1 ratio=6, pll_lock high 20 cycles after pll_en -> done at REQ-033 latency +19, err=0, pll_ratio=6, pll_bypass=0.
REQ-037 Running, new req pllen=1 ratio=11 -> pll_bypass=1 before pll_en=0, pll_ratio=11 only after 16 low cycles, relock, bypass released.
REQ-038 req ratio=1 -> err=1, outputs unchanged, busy never asserted.
REQ-039 pll_lock never high -> done after 4096 WAIT_LOCK cycles, err=2, pll_en=0, pll_bypass=1; lock toggling every 4 cycles also times out.
REQ-040 Locked in IDLE, pll_lock drops 1 cycle -> lock_lost=1, pll_bypass=1; next req clears lock_lost.
REQ-041 rst_n asserted in WAIT_LOCK -> outputs at REQ-034 values asynchronously, no done pulse.
